// File: rtl/world_pkg.sv
// rtl/world_pkg.sv - shared world geometry and automaton port field widths
package world_pkg;
  // World geometry: WORLD_DIM x WORLD_DIM single-bit cells
  localparam int WORLD_DIM = 64;
  localparam int IDX_W     = 6;

  // Automaton read/write port field widths
  localparam int ROW_W  = IDX_W;
  localparam int COL_W  = IDX_W;
  localparam int CELL_W = 1;

  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/world_ram.sv
// rtl/world_ram.sv - 64x64 single-bit world array, automaton port A and host port B
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (b_dout only)
//   a_row, a_col       port A cell address (automaton)
//   a_we, a_din        port A synchronous single-bit write
//   a_dout             port A asynchronous read of mem[a_row][a_col]
//   b_row, b_col       port B cell address (host)
//   b_we, b_din        port B synchronous single-bit write
//   b_dout             port B registered read, returns the pre-edge cell value
//
// The caller guarantees a_we and b_we are never both high.
import world_pkg::*;

module world_ram (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] a_row,
  input  logic [IDX_W-1:0] a_col,
  input  logic             a_we,
  input  logic             a_din,
  output logic             a_dout,
  input  logic [IDX_W-1:0] b_row,
  input  logic [IDX_W-1:0] b_col,
  input  logic             b_we,
  input  logic             b_din,
  output logic             b_dout
);

  // Contents are deliberately not reset; the host loads the world.
  logic [WORLD_DIM-1:0] mem [WORLD_DIM];

  assign a_dout = mem[a_row][a_col];

  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_row][a_col] <= a_din;
    end
    if (b_we) begin
      mem[b_row][b_col] <= b_din;
    end
  end

  // Reads the value before this edge's write, so a write shows one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_dout <= 1'b0;
    end else begin
      b_dout <= mem[b_row][b_col];
    end
  end

endmodule

// File: rtl/world_store.sv
// rtl/world_store.sv - world memory responder with generation commit control
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   row, col              automaton cell address
//   world_we, world_out   automaton cell write (lands only while busy)
//   world_in              combinational cell value at (row, col)
//   update_done           automaton generation boundary pulse
//   run                   level: commit every generation
//   step                  pulse: commit exactly one generation
//   host_we, host_row,
//   host_col, host_din    host cell write (accepted only while not busy)
//   host_dout             registered cell value at (host_row, host_col)
//   host_ack, host_nack   host write accepted / rejected, one cycle later
//   busy                  current generation is being committed
//   gen_count             committed generations, wraps
//   gen_tick              pulse after each committed generation closes
import world_pkg::*;

module world_store #(
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] row,
  input  logic [IDX_W-1:0] col,
  input  logic             world_we,
  input  logic             world_out,
  output logic             world_in,
  input  logic             update_done,
  input  logic             run,
  input  logic             step,
  input  logic             host_we,
  input  logic [IDX_W-1:0] host_row,
  input  logic [IDX_W-1:0] host_col,
  input  logic             host_din,
  output logic             host_dout,
  output logic             host_ack,
  output logic             host_nack,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             gen_tick
);

  logic commit;
  logic step_pending;
  logic auto_wr;
  logic host_wr;

  // Writes are gated by reset so a reset edge stops automaton writes at once.
  // While committing, the host is locked out, so the two ports never collide.
  assign auto_wr = rst_n & commit & world_we;
  assign host_wr = rst_n & ~commit & host_we;
  assign busy    = commit;

  world_ram u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_row  (row),
    .a_col  (col),
    .a_we   (auto_wr),
    .a_din  (world_out),
    .a_dout (world_in),
    .b_row  (host_row),
    .b_col  (host_col),
    .b_we   (host_wr),
    .b_din  (host_din),
    .b_dout (host_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit       <= 1'b0;
      step_pending <= 1'b0;
      gen_count    <= '0;
      gen_tick     <= 1'b0;
      host_ack     <= 1'b0;
      host_nack    <= 1'b0;
    end else begin
      // Host arbitration is judged against the commit value before this edge.
      host_ack  <= host_we & ~commit;
      host_nack <= host_we & commit;

      if (update_done) begin
        // Any pending or coincident step is consumed here, even when run
        // already authorises the next generation.
        commit       <= run | step_pending | step;
        step_pending <= 1'b0;
        gen_tick     <= commit;
        if (commit) begin
          gen_count <= gen_count + 1'b1;
        end
      end else begin
        gen_tick <= 1'b0;
        if (step) begin
          step_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_world_store.sv
// tb/tb_world_store.sv - randomized and directed self-checking bench for world_store
module tb_world_store;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [5:0]  row, col, host_row, host_col;
  logic        world_we, world_out, world_in, update_done, run, step;
  logic        host_we, host_din, host_dout, host_ack, host_nack, busy, gen_tick;
  logic [15:0] gen_count;

  world_store #(.GEN_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .world_we    (world_we),
    .world_out   (world_out),
    .world_in    (world_in),
    .update_done (update_done),
    .run         (run),
    .step        (step),
    .host_we     (host_we),
    .host_row    (host_row),
    .host_col    (host_col),
    .host_din    (host_din),
    .host_dout   (host_dout),
    .host_ack    (host_ack),
    .host_nack   (host_nack),
    .busy        (busy),
    .gen_count   (gen_count),
    .gen_tick    (gen_tick)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the world as a plain bit grid plus the generation rules.
  bit ref_mem [64][64];
  bit known   [64][64];
  bit authorised;
  bit step_req;
  int gens;
  bit exp_tick, exp_ack, exp_nack, exp_dout, exp_dout_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    world_we = 0; world_out = 0; update_done = 0; step = 0;
    host_we = 0; host_din = 0;
  endtask

  // One clock: check world_in before the edge, advance the model, check after.
  task automatic tick();
    bit old_cell, old_known;
    #1;
    if (known[row][col]) check("world_in", world_in, ref_mem[row][col]);
    if (!rst_n) begin
      authorised = 0; step_req = 0; gens = 0;
      exp_tick = 0; exp_ack = 0; exp_nack = 0;
      exp_dout = 0; exp_dout_known = 1;
    end else begin
      old_cell  = ref_mem[host_row][host_col];
      old_known = known[host_row][host_col];
      exp_ack   = host_we && !authorised;
      exp_nack  = host_we && authorised;
      if (authorised && world_we) begin
        ref_mem[row][col] = world_out; known[row][col] = 1;
      end
      if (host_we && !authorised) begin
        ref_mem[host_row][host_col] = host_din; known[host_row][host_col] = 1;
      end
      if (update_done) begin
        exp_tick = authorised;
        if (authorised) gens = (gens + 1) % 65536;
        authorised = run || step_req || step;
        step_req = 0;
      end else begin
        exp_tick = 0;
        if (step) step_req = 1;
      end
      exp_dout = old_cell;
      exp_dout_known = old_known;
    end
    @(posedge clk);
    #1;
    check("busy", busy, authorised);
    check("gen_count", gen_count, gens);
    check("gen_tick", gen_tick, exp_tick);
    check("host_ack", host_ack, exp_ack);
    check("host_nack", host_nack, exp_nack);
    if (exp_dout_known) check("host_dout", host_dout, exp_dout);
  endtask

  initial begin
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) known[r][c] = 0;
    authorised = 0; step_req = 0; gens = 0;
    rst_n = 0; run = 0; row = 0; col = 0; host_row = 0; host_col = 0;
    idle();

    // Reset held two cycles
    tick();
    tick();
    rst_n = 1;

    // Host loads the whole world with random data
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        host_we = 1; host_row = r[5:0]; host_col = c[5:0]; host_din = $urandom_range(0, 1);
        row = $urandom_range(0, 63); col = $urandom_range(0, 63);
        tick();
      end
    end
    idle();

    // Host write (5,7)=1, then read back on both ports
    host_we = 1; host_row = 5; host_col = 7; host_din = 1;
    tick();
    idle(); row = 5; col = 7;
    tick();
    check("cell_5_7", host_dout, 1);

    // Unauthorised generation: automaton writes all ones, all dropped
    run = 0;
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        world_we = 1; world_out = 1; row = r[5:0]; col = c[5:0];
        tick();
      end
    end
    idle(); update_done = 1;
    tick();
    idle();
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        row = r[5:0]; col = c[5:0]; host_row = r[5:0]; host_col = c[5:0];
        tick();
      end
    end

    // Single step: one committed generation, the next one dropped
    step = 1; tick(); idle();
    tick();
    update_done = 1; tick(); idle();
    world_we = 1; world_out = 1; row = 0; col = 0; tick();
    row = 63; col = 63; tick();
    idle(); update_done = 1; tick(); idle();
    world_we = 1; world_out = 0; row = 0; col = 0; tick();
    idle(); row = 63; col = 63; host_row = 0; host_col = 0; tick();
    tick();
    check("step_gen", gen_count, 1);
    check("step_cell", host_dout, 1);

    // Run across three boundaries with a rejected host write mid-generation
    run = 1;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 6; k++) begin
        world_we = $urandom_range(0, 1); world_out = $urandom_range(0, 1);
        row = $urandom_range(0, 63); col = $urandom_range(0, 63);
        host_we = (k == 3); host_row = 9; host_col = 9; host_din = ~ref_mem[9][9];
        tick();
      end
      idle(); update_done = 1; tick(); idle();
    end
    check("run_gen", gen_count, 3);

    // Reset in the middle of a committed generation
    world_we = 1; world_out = 1; row = 1; col = 1; tick();
    rst_n = 0; world_out = 0; row = 2; col = 2; tick();
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      world_we = 1; world_out = $urandom_range(0, 1);
      row = $urandom_range(0, 63); col = $urandom_range(0, 63);
      tick();
    end
    idle(); update_done = 1; tick(); idle();
    run = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 31) == 0) run = ~run;
      step        = ($urandom_range(0, 15) == 0);
      update_done = ($urandom_range(0, 11) == 0);
      world_we    = $urandom_range(0, 1);
      world_out   = $urandom_range(0, 1);
      row         = $urandom_range(0, 63);
      col         = $urandom_range(0, 63);
      host_we     = ($urandom_range(0, 3) == 0);
      host_din    = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        host_row = row; host_col = col;
      end else begin
        host_row = $urandom_range(0, 63); host_col = $urandom_range(0, 63);
      end
      tick();
    end
    rst_n = 1; idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
